// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and helpers for the fpadd driver
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [31:0] fp_negate(input logic [31:0] x);
    return {~x[31], x[30:0]};
  endfunction

endpackage

// File: rtl/fpadd_driver.sv
// rtl/fpadd_driver.sv - start/done initiator for the multi-cycle fp adder core
import fp_pkg::*;

module fpadd_driver #(
  parameter int          TIMEOUT = 511,
  parameter int          TO_W    = $clog2(TIMEOUT + 1),
  parameter logic [31:0] QNAN_V  = fp_pkg::QNAN
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_timeout,
  output logic        fp_start,
  output logic [31:0] fp_a,
  output logic [31:0] fp_b,
  input  logic        fp_done,
  input  logic [31:0] fp_sum,
  output logic        busy
);

  state_e            state_q;
  logic [TO_W-1:0]   wd_q;
  logic [TO_W-1:0]   wd_d;
  logic              wd_hit;
  logic              fp_start_q;
  logic              out_valid_q;
  logic              out_timeout_q;
  logic [31:0]       out_sum_q;
  logic [31:0]       fp_a_q;
  logic [31:0]       fp_b_q;

  assign wd_d   = wd_q + 1'b1;
  assign wd_hit = (wd_q == TO_W'(TIMEOUT - 1));

  // fp_done is deliberately not looked at in ISSUE: the previous run's done
  // level is still high there and must not be mistaken for this result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      fp_start_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_timeout_q <= 1'b0;
      out_sum_q     <= '0;
      fp_a_q        <= '0;
      fp_b_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            fp_a_q     <= in_a;
            fp_b_q     <= in_sub ? fp_negate(in_b) : in_b;
            fp_start_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          fp_start_q <= 1'b0;
          wd_q       <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          wd_q <= wd_d;
          if (fp_done) begin
            out_sum_q     <= fp_sum;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (wd_hit) begin
            out_sum_q     <= QNAN_V;
            out_timeout_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign fp_start    = fp_start_q;
  assign out_valid   = out_valid_q;
  assign out_timeout = out_timeout_q;
  assign out_sum     = out_sum_q;
  assign fp_a        = fp_a_q;
  assign fp_b        = fp_b_q;

endmodule

// File: tb/tb_fpadd_driver.sv
// tb/tb_fpadd_driver.sv - directed bench for fpadd_driver
module tb_fpadd_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_timeout;
  logic        fp_start;
  logic [31:0] fp_a;
  logic [31:0] fp_b;
  logic        fp_done;
  logic [31:0] fp_sum;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  fpadd_driver #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_timeout(out_timeout),
    .fp_start(fp_start), .fp_a(fp_a), .fp_b(fp_b), .fp_done(fp_done), .fp_sum(fp_sum),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fp_start) start_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Present one pair; returns #1 after the accepting edge (driver in ISSUE).
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  // Core model: done drops after the WAIT entry edge, rises after `dly` edges.
  task automatic core_run(input int dly, input logic [31:0] sum);
    @(posedge clk); #1;
    fp_done = 1'b0;
    repeat (dly) @(posedge clk);
    #1;
    fp_done = 1'b1;
    fp_sum  = sum;
  endtask

  initial begin
    int n;
    int sc;
    logic [31:0] held_sum;
    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    out_ready = 1'b1; fp_done = 1'b0; fp_sum = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_fp_start", {31'd0, fp_start}, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_fp_ab", fp_a | fp_b, 32'd0);

    // add 1.0 + 2.0
    drive_op(32'h3F80_0000, 32'h4000_0000, 1'b0);
    check("add_fp_start", {31'd0, fp_start}, 32'd1);
    check("add_fp_a", fp_a, 32'h3F80_0000);
    check("add_fp_b", fp_b, 32'h4000_0000);
    check("add_busy", {31'd0, busy}, 32'd1);
    core_run(2, 32'h4040_0000);
    wait_out("add_out_valid");
    check("add_out_sum", out_sum, 32'h4040_0000);
    check("add_out_to", {31'd0, out_timeout}, 32'd0);
    check("add_starts", start_cnt, 32'd1);
    @(posedge clk); #1;
    check("add_idle", {31'd0, in_ready}, 32'd1);

    // subtract 3.0 - 1.0
    drive_op(32'h4040_0000, 32'h3F80_0000, 1'b1);
    check("sub_fp_b", fp_b, 32'hBF80_0000);
    core_run(3, 32'h4000_0000);
    wait_out("sub_out_valid");
    check("sub_out_sum", out_sum, 32'h4000_0000);
    @(posedge clk); #1;

    // watchdog: done never arrives
    drive_op(32'h1111_1111, 32'h2222_2222, 1'b0);
    @(posedge clk); #1;
    fp_done = 1'b0;
    n = 0;
    for (int i = 1; i <= 60 && n == 0; i++) begin
      @(posedge clk); #1;
      if (out_valid) n = i;
    end
    check("to_latency", n, 32'd16);
    check("to_out_sum", out_sum, 32'h7FC0_0000);
    check("to_out_to", {31'd0, out_timeout}, 32'd1);
    @(posedge clk); #1;

    // stale done across ISSUE, then backpressure in RESP
    out_ready = 1'b0;
    fp_done = 1'b1; fp_sum = 32'hDEAD_BEEF;
    drive_op(32'h3333_3333, 32'h4444_4444, 1'b0);
    core_run(5, 32'h1234_5678);
    wait_out("stale_out_valid");
    check("stale_out_sum", out_sum, 32'h1234_5678);
    check("stale_out_to", {31'd0, out_timeout}, 32'd0);
    sc = start_cnt;
    held_sum = out_sum;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'h5555_5555; fp_sum = 32'hCAFE_F00D;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_sum", out_sum, held_sum);
      check("bp_out_to", {31'd0, out_timeout}, 32'd0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_no_start", start_cnt, sc);
    check("bp_fp_a_held", fp_a, 32'h3333_3333);

    // asynchronous reset three cycles into WAIT
    drive_op(32'h4000_0000, 32'h4000_0000, 1'b0);
    @(posedge clk); #1;
    fp_done = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_fp_start", {31'd0, fp_start}, 32'd0);
    check("mrst_fp_ab", fp_a | fp_b, 32'd0);
    check("mrst_out_sum", out_sum, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("mrst_no_out", n, 32'd0);
    drive_op(32'h4000_0000, 32'h4000_0000, 1'b0);
    core_run(1, 32'h4080_0000);
    wait_out("mrst_next_valid");
    check("mrst_next_sum", out_sum, 32'h4080_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
